// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and
// memory-wait freezes for a five-stage in-order pipeline.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id_rs_addr, id_rt_addr   source registers of the decode instruction
//   id_uses_rt               decode instruction reads rt
//   ex_mem_read, ex_rt_addr  load in D/X and its destination register
//   ex_redirect              taken branch/jump resolved in execute
//   mem_busy                 data memory not ready, freeze everything
//   pc_write, fd_write       PC and F/D register enables
//   fd_flush                 F/D loads a no-op
//   dx_write, dx_bubble      D/X enable and bubble insert
//   stall_count              saturating count of cycles with pc_write=0
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt_addr,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        fd_write,
    output logic        fd_flush,
    output logic        dx_write,
    output logic        dx_bubble,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_d;
    logic        load_use;
    logic        rs_hit;
    logic        rt_hit;

    // $zero is never a real dependency, so a load into r0 never stalls.
    assign rs_hit   = (ex_rt_addr == id_rs_addr);
    assign rt_hit   = id_uses_rt && (ex_rt_addr == id_rt_addr);
    assign load_use = ex_mem_read && (ex_rt_addr != 5'd0)
                      && (rs_hit || rt_hit);

    always_comb begin
        pc_write  = 1'b1;
        fd_write  = 1'b1;
        fd_flush  = 1'b0;
        dx_write  = 1'b1;
        dx_bubble = 1'b0;
        state_d   = RUN;
        if (!rst) begin
            // Hold fetch and stream bubbles into the pipeline.
            pc_write  = 1'b0;
            fd_write  = 1'b0;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write = 1'b0;
            fd_write = 1'b0;
            dx_write = 1'b0;
            state_d  = MEM_WAIT;
        end else if (ex_redirect) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
            state_d   = FLUSH;
        end else if (state_q == FLUSH) begin
            // Decode holds a flushed no-op; any apparent load-use is stale.
            state_d = RUN;
        end else if (load_use) begin
            // D/X takes the bubble, so next cycle the hazard is gone.
            pc_write  = 1'b0;
            fd_write  = 1'b0;
            dx_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table for single-cycle
// decisions plus hand sequences for reset, wait and saturation cases.
module tb_hazard_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt_addr;
    logic        ex_redirect;
    logic        mem_busy;
    logic        pc_write;
    logic        fd_write;
    logic        fd_flush;
    logic        dx_write;
    logic        dx_bubble;
    logic [15:0] stall_count;

    int checks;
    int errors;

    hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt_addr  (ex_rt_addr),
        .ex_redirect (ex_redirect),
        .mem_busy    (mem_busy),
        .pc_write    (pc_write),
        .fd_write    (fd_write),
        .fd_flush    (fd_flush),
        .dx_write    (dx_write),
        .dx_bubble   (dx_bubble),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output code order: {pc_write, fd_write, fd_flush, dx_write, dx_bubble}
    localparam logic [4:0] NORM  = 5'b11010;
    localparam logic [4:0] STALL = 5'b00011;
    localparam logic [4:0] REDIR = 5'b11111;
    localparam logic [4:0] FRZ   = 5'b00000;
    localparam logic [4:0] RSTO  = 5'b00111;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        ur;
        logic        mr;
        logic [4:0]  ert;
        logic        rd;
        logic        mb;
        logic [4:0]  exp_o;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic        ur,
        input logic        mr,
        input logic [4:0]  ert,
        input logic        rd,
        input logic        mb,
        input logic [4:0]  exp_o,
        input logic [15:0] exp_cnt
    );
        vec_t v;
        v.rs = rs; v.rt = rt; v.ur = ur; v.mr = mr; v.ert = ert;
        v.rd = rd; v.mb = mb; v.exp_o = exp_o; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    function automatic logic [4:0] outs();
        return {pc_write, fd_write, fd_flush, dx_write, dx_bubble};
    endfunction

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic mr,
                         input logic [4:0] ert, input logic rd,
                         input logic mb);
        id_rs_addr  = rs;
        id_rt_addr  = rt;
        id_uses_rt  = ur;
        ex_mem_read = mr;
        ex_rt_addr  = ert;
        ex_redirect = rd;
        mem_busy    = mb;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk("rst_cnt", stall_count, 16'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        #2;
        chk("reset_outs", {11'd0, outs()}, {11'd0, RSTO});
        chk("reset_cnt", stall_count, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();

        //         rs    rt    ur mr ert   rd mb  outs   cnt
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, NORM,  16'd0));
        vecs.push_back(mk(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, STALL, 16'd0));
        vecs.push_back(mk(5'd5, 5'd0, 0, 0, 5'd0, 0, 0, NORM,  16'd1));
        vecs.push_back(mk(5'd0, 5'd0, 0, 1, 5'd0, 0, 0, NORM,  16'd1));
        vecs.push_back(mk(5'd3, 5'd7, 0, 1, 5'd7, 0, 0, NORM,  16'd1));
        vecs.push_back(mk(5'd3, 5'd7, 1, 1, 5'd7, 0, 0, STALL, 16'd1));
        vecs.push_back(mk(5'd3, 5'd7, 1, 0, 5'd0, 0, 0, NORM,  16'd2));
        vecs.push_back(mk(5'd5, 5'd0, 0, 1, 5'd5, 1, 0, REDIR, 16'd2));
        vecs.push_back(mk(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, NORM,  16'd2));
        vecs.push_back(mk(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, STALL, 16'd2));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, FRZ,   16'd3));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, FRZ,   16'd4));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, FRZ,   16'd5));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, REDIR, 16'd6));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, NORM,  16'd6));
        vecs.push_back(mk(5'd9, 5'd0, 0, 1, 5'd9, 0, 1, FRZ,   16'd6));
        vecs.push_back(mk(5'd9, 5'd0, 0, 1, 5'd9, 0, 0, STALL, 16'd7));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, NORM,  16'd8));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, REDIR, 16'd8));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, FRZ,   16'd8));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, NORM,  16'd9));
        vecs.push_back(mk(5'd5, 5'd4, 0, 1, 5'd4, 0, 0, NORM,  16'd9));
        vecs.push_back(mk(5'd5, 5'd5, 1, 0, 5'd5, 0, 0, NORM,  16'd9));
        vecs.push_back(mk(5'd31, 5'd2, 1, 1, 5'd2, 0, 0, STALL, 16'd9));
        vecs.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, NORM,  16'd10));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].mr,
                  vecs[i].ert, vecs[i].rd, vecs[i].mb);
            #1;
            chk($sformatf("vec%0d_outs", i), {11'd0, outs()},
                {11'd0, vecs[i].exp_o});
            chk($sformatf("vec%0d_cnt", i), stall_count,
                vecs[i].exp_cnt);
        end

        // Async reset from MEM_WAIT with stall_count 9.
        reset_pulse();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #2;
        chk("wait9_cnt", stall_count, 16'd9);
        rst = 1'b0;
        #1;
        chk("async_cnt", stall_count, 16'd0);
        chk("async_outs", {11'd0, outs()}, {11'd0, RSTO});
        @(posedge clk);
        #1;
        chk("held_cnt", stall_count, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        #1;
        chk("post_wait_outs", {11'd0, outs()}, {11'd0, NORM});
        @(negedge clk);
        drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
        #1;
        chk("post_wait_lu", {11'd0, outs()}, {11'd0, STALL});

        // Reset during FLUSH: no stale flush state may survive.
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
        drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
        #1;
        chk("post_flush_lu", {11'd0, outs()}, {11'd0, STALL});

        // Saturation of stall_count.
        reset_pulse();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        repeat (65534) @(posedge clk);
        #2;
        chk("sat_fffe", stall_count, 16'hFFFE);
        repeat (3) @(posedge clk);
        #2;
        chk("sat_ffff", stall_count, 16'hFFFF);
        chk("sat_outs", {11'd0, outs()}, {11'd0, FRZ});
        repeat (2) @(posedge clk);
        #2;
        chk("sat_hold", stall_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have: clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-002 The block SHALL have: rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have: id_rs_addr  in  5  rs field of the instruction in decode.
REQ-004 The block SHALL have: id_rt_addr  in  5  rt field of the instruction in decode.
REQ-005 The block SHALL have: id_uses_rt  in  1  the decode instruction reads rt as a source.
REQ-006 The block SHALL have: ex_mem_read  in  1  mem_read of the instruction held in the D/X register.
REQ-007 The block SHALL have: ex_rt_addr  in  5  rt destination of the instruction held in the D/X register.
REQ-008 The block SHALL have: ex_redirect  in  1  taken branch or jump resolved in execute this cycle.
REQ-009 The block SHALL have: mem_busy  in  1  data memory not ready; pipeline must freeze.
REQ-010 The block SHALL have: pc_write  out  1  PC register enable.
REQ-011 The block SHALL have: fd_write  out  1  F/D register enable.
REQ-012 The block SHALL have: fd_flush  out  1  F/D register loads a no-op.
REQ-013 The block SHALL have: dx_write  out  1  D/X register enable.
REQ-014 The block SHALL have: dx_bubble  out  1  D/X register loads a bubble: branch=0, alu_op=3'h1 (no-op), all write/read controls 0.
REQ-015 The block SHALL have: stall_count  out  16  saturating count of cycles with pc_write=0.

Function
REQ-016 State register SHALL hold one of RUN, MEM_WAIT, FLUSH; the state is the only registered control.
REQ-017 Control outputs SHALL be a combinational function of the current state and the current inputs, with no added latency.
REQ-018 load_use SHALL be 1 iff ex_mem_read=1, ex_rt_addr!=0, and (ex_rt_addr==id_rs_addr or (id_uses_rt=1 and ex_rt_addr==id_rt_addr)).
REQ-019 Priority SHALL be: mem_busy > ex_redirect > (state==FLUSH) > load_use > normal.
REQ-020 mem_busy=1 SHALL give pc_write=0, fd_write=0, dx_write=0, fd_flush=0, dx_bubble=0, and next state MEM_WAIT.
REQ-021 ex_redirect=1 with mem_busy=0 SHALL give pc_write=1, fd_write=1, fd_flush=1, dx_write=1, dx_bubble=1, and next state FLUSH.
REQ-022 State FLUSH with no higher-priority event SHALL give all enables 1 and flush/bubble 0, suppress load_use for that cycle, and go to RUN next.
REQ-023 load_use=1 in RUN or MEM_WAIT, with no higher-priority event, SHALL give pc_write=0, fd_write=0, dx_write=1, dx_bubble=1, fd_flush=0, and keep/enter RUN, producing exactly one bubble per hazard.
REQ-024 Otherwise the block SHALL drive pc_write=fd_write=dx_write=1, fd_flush=dx_bubble=0, and go to RUN.
REQ-025 MEM_WAIT with mem_busy=0 SHALL resume in the same cycle: evaluate REQ-021..024 in that cycle; a redirect asserted during the wait SHALL still be honoured on the release cycle.
REQ-026 stall_count SHALL increment by 1 on each posedge where pc_write=0, saturate at 16'hFFFF, and never wrap.
REQ-027 Simultaneous ex_redirect and load_use SHALL resolve to redirect only; no stall is counted.

Reset
REQ-028 rst=0 SHALL immediately, without a clock, force state=RUN and stall_count=0.
REQ-029 While rst=0, outputs SHALL be pc_write=0, fd_write=0, dx_write=1, dx_bubble=1, fd_flush=1, so the pipeline fills with bubbles.
REQ-030 Reset deasserted mid-stall or mid-FLUSH SHALL resume from RUN with no pending bubble.

Verification
REQ-031 Load-use: ex_mem_read=1, ex_rt_addr=5, id_rs_addr=5 for one cycle -> pc_write=0, dx_bubble=1 for exactly 1 cycle, stall_count 0->1.
REQ-032 $zero guard: ex_mem_read=1, ex_rt_addr=0, id_rs_addr=0 -> no stall, all enables 1, stall_count stays 0.
REQ-033 rt gating: ex_rt_addr=7, id_rt_addr=7, id_uses_rt=0 -> no stall; with id_uses_rt=1 -> one bubble.
REQ-034 Redirect: ex_redirect=1 -> fd_flush=1, dx_bubble=1 that cycle; next cycle state FLUSH with a load_use pattern on inputs -> no stall, then RUN.
REQ-035 mem_busy held 3 cycles while ex_redirect=1 -> all enables 0 for 3 cycles, stall_count=3; release cycle -> fd_flush=1, dx_bubble=1.
REQ-036 Async reset: assert rst=0 between clock edges while in MEM_WAIT with stall_count=9 -> state RUN and stall_count=0 before the next edge; saturation preloaded at 16'hFFFE with 3 stall cycles -> 16'hFFFF.
